// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  localparam int          MC_TIMEOUT_DEFAULT = 32;
  localparam logic [31:0] NOP                = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_watchdog.sv
// Multi-cycle watchdog: counts enabled cycles and flags expiry once the count
// reaches the limit, so a hung multi-cycle unit cannot stall the pipe forever.
module mc_watchdog (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired,
  output logic [7:0] count
);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count >= limit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: branch flush, load-use stall, multi-cycle wait with
// watchdog release. Define HAZARD_FWD_EN to enable W->E operand forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic        reg_write_e,
  input  logic        load_e,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_w,
  input  logic        branch_taken_e,
  input  logic        mc_start_e,
  input  logic        mc_done,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        flush_d,
  output logic        flush_e,
  output logic        fwd_a_e,
  output logic        fwd_b_e,
  output logic        mc_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [7:0] WD_LIMIT = 8'(MC_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       load_use;
  logic       wd_expired;
  logic [7:0] wd_count;
  logic       unused_count;

  mc_watchdog u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != MC_WAIT),
    .enable  (state == MC_WAIT),
    .limit   (WD_LIMIT),
    .expired (wd_expired),
    .count   (wd_count)
  );

  // The live count is only for debug visibility; expiry is all we act on.
  assign unused_count = ^wd_count;

`ifdef HAZARD_FWD_EN
  assign load_use = load_e && reg_write_e && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign fwd_a_e  = !rst && reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e);
  assign fwd_b_e  = !rst && reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e);
`else
  logic unused_fwd;
  // Without a bypass path every in-flight register write must stall D.
  assign load_use   = reg_write_e && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign fwd_a_e    = 1'b0;
  assign fwd_b_e    = 1'b0;
  assign unused_fwd = ^{load_e, rs1_e, rs2_e, rd_w, reg_write_w};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (!branch_taken_e && mc_start_e) state_nxt = MC_WAIT;
      MC_WAIT: if (mc_done || wd_expired)         state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    mc_timeout = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (mc_start_e) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        MC_WAIT: begin
          // A result arriving on the expiry cycle is a normal completion.
          if (mc_done) begin
            mc_timeout = 1'b0;
          end else if (wd_expired) begin
            mc_timeout = 1'b1;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_d && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
